// File: rtl/dm_mem_ctrl.sv
// dm_mem_ctrl: registered debug-memory slave for the RISC-V Debug Module.
// Decodes hart-side bus accesses to the debug memory window, keeps per-hart
// halted/go/resume flags and sequences abstract-command execution.
// Optional feature macro: DM_MEM_CTRL_BE_EN (byte enables forwarded to the
// data registers and enforced as full-word on status writes).
module dm_mem_ctrl #(
    parameter int          NrHarts        = 1,
    parameter int          BusWidth       = 32,
    parameter int          DbgAddressBits = 12,
    parameter int unsigned DataAddr       = 'h380,
    parameter int          DataCount      = 2,
    parameter int          ProgBufSize    = 8,
    parameter int          AbsCmdWords    = 10,
    parameter int unsigned ResumeAddr     = 'h804,
    localparam int         HartSelW       = (NrHarts > 1) ? $clog2(NrHarts) : 1,
    localparam int         IdxW           = $clog2(DataCount) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [BusWidth-1:0]       addr_i,
    input  logic [BusWidth-1:0]       wdata_i,
    input  logic [BusWidth/8-1:0]     be_i,
    output logic                      rvalid_o,
    output logic [BusWidth-1:0]       rdata_o,
    output logic                      err_o,
    input  logic                      go_i,
    input  logic                      resume_i,
    input  logic [HartSelW-1:0]       hartsel_i,
    input  logic [32*DataCount-1:0]   data_i,
    input  logic [32*ProgBufSize-1:0] progbuf_i,
    input  logic [32*AbsCmdWords-1:0] abscmd_i,
    output logic                      data_we_o,
    output logic [IdxW-1:0]           data_idx_o,
    output logic [31:0]               data_wdata_o,
    output logic [3:0]                data_be_o,
    output logic [NrHarts-1:0]        halted_o,
    output logic [NrHarts-1:0]        resumeack_o,
    output logic                      exception_o,
    output logic                      cmd_busy_o
);

    // Program buffer sits directly below the data words, abstract command below that.
    localparam int unsigned PbBase  = DataAddr - 4 * ProgBufSize;
    localparam int unsigned AcBase  = PbBase - 4 * AbsCmdWords;
    localparam int unsigned DataEnd = DataAddr + 4 * DataCount;

    localparam logic [31:0] AddrHalted   = 32'h100;
    localparam logic [31:0] AddrGoing    = 32'h108;
    localparam logic [31:0] AddrResuming = 32'h110;
    localparam logic [31:0] AddrExcept   = 32'h118;
    localparam logic [31:0] AddrWhereTo  = 32'h300;
    localparam logic [31:0] FlagsLo      = 32'h400;
    localparam logic [31:0] FlagsHi      = 32'h7FC;

    typedef enum logic [1:0] {S_IDLE, S_GO, S_EXEC} state_e;

    state_e              r_state;
    logic [HartSelW-1:0] r_cmd_hart;
    logic [NrHarts-1:0]  r_halted;
    logic [NrHarts-1:0]  r_go;
    logic [NrHarts-1:0]  r_resume;

    logic [31:0]         w_waddr;
    logic                w_in_data, w_in_flags;
    logic                w_is_halt, w_is_going, w_is_res, w_is_exc, w_status_be_ok;
    logic                w_wid_ok, w_hs_ok, w_wr_ok, w_rd_hit, w_err;
    logic [31:0]         w_rdata;
    logic [31:0]         w_go_ext, w_res_ext, w_halt_ext;
    logic [HartSelW-1:0] w_wid;
    logic [NrHarts-1:0]  w_id_oh, w_hs_oh, w_halted_upd;
    logic                w_wr, w_halt_wr, w_going_wr, w_res_wr, w_exc_wr;
    logic                w_end_cmd, w_to_exec, w_exc_pulse, w_idle_after;
    logic                w_sel_halted, w_go_ok, w_res_ok;
    logic [31:0]         w_data_rel;
    logic                w_unused;

    // Word-aligned offset inside the decoded window.
    assign w_waddr    = 32'(addr_i[DbgAddressBits-1:0]) & 32'hFFFF_FFFC;
    assign w_in_data  = (w_waddr >= DataAddr) && (w_waddr < DataEnd);
    assign w_in_flags = (w_waddr >= FlagsLo) && (w_waddr <= FlagsHi);
    assign w_is_halt  = (w_waddr == AddrHalted);
    assign w_is_going = (w_waddr == AddrGoing);
    assign w_is_res   = (w_waddr == AddrResuming);
    assign w_is_exc   = (w_waddr == AddrExcept);

`ifdef DM_MEM_CTRL_BE_EN
    assign w_status_be_ok = (be_i[3:0] == 4'hF);
    assign data_be_o      = be_i[3:0];
`else
    assign w_status_be_ok = 1'b1;
    assign data_be_o      = 4'hF;
`endif

    // Hart ids written to Halted/Resuming are range-checked on the full word.
    assign w_wid    = wdata_i[HartSelW-1:0];
    assign w_wid_ok = (wdata_i < 32'(NrHarts));
    assign w_hs_ok  = (32'(hartsel_i) < 32'(NrHarts));

    assign w_wr_ok = w_in_data
                   | (w_status_be_ok & ((w_is_halt & w_wid_ok) | (w_is_res & w_wid_ok)
                                        | w_is_going | w_is_exc));

    assign w_go_ext  = 32'(r_go);
    assign w_res_ext = 32'(r_resume);

    // Read mux across WhereTo, data, program buffer, abstract command and flag regions.
    always_comb begin
        w_rdata  = '0;
        w_rd_hit = 1'b0;
        if (w_waddr == AddrWhereTo) begin
            w_rd_hit = 1'b1;
            w_rdata  = (r_state != S_IDLE) ? AcBase : ResumeAddr;
        end
        for (int i = 0; i < DataCount; i++) begin
            if (w_waddr == DataAddr + 4 * i) begin
                w_rd_hit = 1'b1;
                w_rdata  = data_i[32*i +: 32];
            end
        end
        for (int i = 0; i < ProgBufSize; i++) begin
            if (w_waddr == PbBase + 4 * i) begin
                w_rd_hit = 1'b1;
                w_rdata  = progbuf_i[32*i +: 32];
            end
        end
        for (int i = 0; i < AbsCmdWords; i++) begin
            if (w_waddr == AcBase + 4 * i) begin
                w_rd_hit = 1'b1;
                w_rdata  = abscmd_i[32*i +: 32];
            end
        end
        if (w_in_flags) begin
            w_rd_hit = 1'b1;
            for (int n = 0; n < 4; n++) begin
                if (32'({w_waddr[9:2], 2'(n)}) < 32'(NrHarts))
                    w_rdata[8*n +: 8] = {6'b0, w_res_ext[{w_waddr[4:2], 2'(n)}],
                                         w_go_ext[{w_waddr[4:2], 2'(n)}]};
            end
        end
    end

    assign w_err = we_i ? ~w_wr_ok : ~w_rd_hit;

    // Data-register writes go out combinationally in the request cycle.
    assign w_data_rel   = w_waddr - DataAddr;
    assign data_we_o    = req_i & we_i & w_in_data;
    assign data_idx_o   = w_data_rel[IdxW+1:2];
    assign data_wdata_o = wdata_i;

    // Side effects of an accepted bus write.
    assign w_wr       = req_i & we_i & ~w_err;
    assign w_halt_wr  = w_wr & w_is_halt;
    assign w_going_wr = w_wr & w_is_going;
    assign w_res_wr   = w_wr & w_is_res;
    assign w_exc_wr   = w_wr & w_is_exc;
    assign w_id_oh    = NrHarts'(1) << w_wid;
    assign w_hs_oh    = NrHarts'(1) << hartsel_i;

    assign w_end_cmd    = (w_halt_wr & (r_state != S_IDLE) & (w_wid == r_cmd_hart))
                        | (w_exc_wr & (r_state == S_EXEC));
    assign w_exc_pulse  = w_exc_wr & (r_state == S_EXEC);
    assign w_to_exec    = w_going_wr & (r_state == S_GO);
    assign w_idle_after = (r_state == S_IDLE) | w_end_cmd;

    // go_i / resume_i see the halted flags and state as left by this cycle's write.
    assign w_halted_upd = (r_halted | (w_halt_wr ? w_id_oh : '0)) & ~(w_res_wr ? w_id_oh : '0);
    assign w_halt_ext   = 32'(w_halted_upd);
    assign w_sel_halted = w_halt_ext[5'(hartsel_i)];
    assign w_go_ok      = go_i & w_idle_after & w_hs_ok & w_sel_halted;
    assign w_res_ok     = resume_i & w_idle_after & w_hs_ok & w_sel_halted;

    assign halted_o   = r_halted;
    assign cmd_busy_o = (r_state != S_IDLE);

    assign w_unused = ^{addr_i[BusWidth-1:DbgAddressBits], addr_i[1:0], be_i};

    // Bus response, per-hart flags, pulses and the abstract-command FSM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o    <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            r_halted    <= '0;
            r_go        <= '0;
            r_resume    <= '0;
            resumeack_o <= '0;
            exception_o <= 1'b0;
            r_state     <= S_IDLE;
            r_cmd_hart  <= '0;
        end else begin
            rvalid_o    <= req_i;
            err_o       <= req_i & w_err;
            rdata_o     <= (req_i & ~we_i & ~w_err) ? w_rdata : '0;
            r_halted    <= w_halted_upd;
            r_go        <= (r_go & ((w_end_cmd | w_to_exec) ? '0 : '1)) | (w_go_ok ? w_hs_oh : '0);
            r_resume    <= (r_resume & ~(w_res_wr ? w_id_oh : '0)) | (w_res_ok ? w_hs_oh : '0);
            resumeack_o <= w_res_wr ? w_id_oh : '0;
            exception_o <= w_exc_pulse;
            if (w_go_ok) begin
                r_state    <= S_GO;
                r_cmd_hart <= hartsel_i;
            end else if (w_end_cmd) begin
                r_state <= S_IDLE;
            end else if (w_to_exec) begin
                r_state <= S_EXEC;
            end
        end
    end

endmodule

// File: tb/tb_dm_mem_ctrl.sv
// Self-checking bench for dm_mem_ctrl (NrHarts = 4): directed plan steps,
// then random bus/go/resume traffic against a behavioural model.
module tb_dm_mem_ctrl;

    localparam int NH = 4;

    logic         clk_i = 1'b0, rst_i = 1'b1;
    logic         req_i = 1'b0, we_i = 1'b0, go_i = 1'b0, resume_i = 1'b0;
    logic [31:0]  addr_i = '0, wdata_i = '0;
    logic [3:0]   be_i = 4'hF;
    logic [1:0]   hartsel_i = '0;
    logic [63:0]  data_i;
    logic [255:0] progbuf_i;
    logic [319:0] abscmd_i;
    logic         rvalid_o, err_o, data_we_o, exception_o, cmd_busy_o;
    logic [31:0]  rdata_o, data_wdata_o;
    logic [1:0]   data_idx_o;
    logic [3:0]   data_be_o, halted_o, resumeack_o;

    int n_chk = 0;
    int n_fail = 0;

    // Model: per-hart flags plus command stage (0 none, 1 waiting for Going, 2 executing).
    bit m_halted[NH], m_go[NH], m_res[NH];
    int m_stage, m_cmd;

    dm_mem_ctrl #(.NrHarts(NH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .go_i(go_i), .resume_i(resume_i), .hartsel_i(hartsel_i),
        .data_i(data_i), .progbuf_i(progbuf_i), .abscmd_i(abscmd_i),
        .data_we_o(data_we_o), .data_idx_o(data_idx_o), .data_wdata_o(data_wdata_o),
        .data_be_o(data_be_o), .halted_o(halted_o), .resumeack_o(resumeack_o),
        .exception_o(exception_o), .cmd_busy_o(cmd_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NH; i++) begin
            m_halted[i] = 0; m_go[i] = 0; m_res[i] = 0;
        end
        m_stage = 0; m_cmd = 0;
    endtask

    function automatic logic [3:0] pack_halted();
        logic [3:0] v;
        for (int i = 0; i < NH; i++) v[i] = m_halted[i];
        return v;
    endfunction

    // Expected error / read data of an access, from the memory map rules.
    function automatic void expect_access(input logic [31:0] addr, input bit we,
                                          input logic [31:0] wd, input logic [3:0] be,
                                          output bit err, output logic [31:0] rd);
        int w;
        int h;
        w = int'(addr & 32'h0000_0FFC);
        err = 1'b0;
        rd = 32'h0;
        if (we) begin
            if (w == 'h380 || w == 'h384 || w == 'h108 || w == 'h118) err = 1'b0;
            else if (w == 'h100 || w == 'h110) err = (wd >= NH);
            else err = 1'b1;
`ifdef DM_MEM_CTRL_BE_EN
            if ((w == 'h100 || w == 'h108 || w == 'h110 || w == 'h118) && be != 4'hF) err = 1'b1;
`endif
        end else begin
            if (w == 'h300) rd = (m_stage != 0) ? 32'h338 : 32'h804;
            else if (w >= 'h380 && w < 'h388) rd = data_i[(w - 'h380) * 8 +: 32];
            else if (w >= 'h360 && w < 'h380) rd = progbuf_i[(w - 'h360) * 8 +: 32];
            else if (w >= 'h338 && w < 'h360) rd = abscmd_i[(w - 'h338) * 8 +: 32];
            else if (w >= 'h400 && w < 'h800) begin
                for (int n = 0; n < 4; n++) begin
                    h = ((w - 'h400) / 4) * 4 + n;
                    if (h < NH) rd[8*n +: 8] = {6'b0, m_res[h], m_go[h]};
                end
            end else err = 1'b1;
        end
    endfunction

    // One bus cycle: drive, check combinational data port, advance model, check response.
    task automatic step(input bit req, input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input bit go, input bit res, input logic [1:0] hs);
        bit          e;
        bit          dwe;
        bit          eexc;
        logic [31:0] rd;
        logic [3:0]  eack;
        int          w;
        int          id;
        req_i = req; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
        go_i = go; resume_i = res; hartsel_i = hs;
        #1;
        expect_access(addr, we, wd, be, e, rd);
        w   = int'(addr & 32'h0000_0FFC);
        id  = int'(wd);
        dwe = req && we && (w == 'h380 || w == 'h384);
        chk("data_we", data_we_o, dwe);
        if (dwe) begin
            chk("data_idx", data_idx_o, (w - 'h380) / 4);
            chk("data_wdata", data_wdata_o, wd);
`ifdef DM_MEM_CTRL_BE_EN
            chk("data_be", data_be_o, be);
`else
            chk("data_be", data_be_o, 4'hF);
`endif
        end
        eack = 4'b0;
        eexc = 1'b0;
        if (req && we && !e) begin
            case (w)
                'h100: begin
                    m_halted[id] = 1;
                    if (m_stage != 0 && id == m_cmd) begin
                        m_stage = 0; m_go[m_cmd] = 0;
                    end
                end
                'h108: if (m_stage == 1) begin m_stage = 2; m_go[m_cmd] = 0; end
                'h110: begin m_halted[id] = 0; m_res[id] = 0; eack[id] = 1'b1; end
                'h118: if (m_stage == 2) begin m_stage = 0; eexc = 1'b1; end
                default: ;
            endcase
        end
        if (res && m_stage == 0 && m_halted[hs]) m_res[hs] = 1;
        if (go && m_stage == 0 && m_halted[hs]) begin
            m_stage = 1; m_cmd = int'(hs); m_go[hs] = 1;
        end
        @(posedge clk_i);
        #1;
        req_i = 0; we_i = 0; go_i = 0; resume_i = 0;
        chk("rvalid", rvalid_o, req);
        chk("err", err_o, req && e);
        chk("rdata", rdata_o, (req && !we && !e) ? rd : 32'h0);
        chk("halted", halted_o, pack_halted());
        chk("busy", cmd_busy_o, m_stage != 0);
        chk("resumeack", resumeack_o, eack);
        chk("exception", exception_o, eexc);
    endtask

    initial begin
        logic [31:0] a, hi, wd;
        logic [3:0]  be;
        int          sel, r;
        data_i = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) progbuf_i[32*i +: 32] = $urandom;
        for (int i = 0; i < 10; i++) abscmd_i[32*i +: 32] = $urandom;
        model_reset();

        #1;
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_halted", halted_o, 0);
        chk("rst_busy", cmd_busy_o, 0);
        chk("rst_pulses", {resumeack_o, exception_o, err_o}, 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;

        // Directed plan.
        step(1, 0, 'h300, 0, 4'hF, 0, 0, 0);
        chk("plan_whereto_idle", rdata_o, 32'h804);
        step(1, 1, 'h100, 2, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 4'hF, 1, 0, 2);
        chk("plan_busy_go", cmd_busy_o, 1);
        step(1, 0, 'h400, 0, 4'hF, 0, 0, 0);
        chk("plan_flags_go", rdata_o, 32'h0001_0000);
        step(1, 0, 'h300, 0, 4'hF, 0, 0, 0);
        chk("plan_whereto_go", rdata_o, 32'h338);
        step(1, 1, 'h108, 0, 4'hF, 0, 0, 0);
        step(1, 0, 'h400, 0, 4'hF, 0, 0, 0);
        chk("plan_flags_exec", rdata_o, 32'h0);
        step(1, 1, 'h100, 2, 4'hF, 0, 0, 0);
        chk("plan_busy_done", cmd_busy_o, 0);
        step(0, 0, 0, 0, 4'hF, 1, 0, 2);
        step(1, 1, 'h108, 0, 4'hF, 0, 0, 0);
        step(1, 1, 'h118, 0, 4'hF, 0, 0, 0);
        chk("plan_exc_pulse", exception_o, 1);
        step(0, 0, 0, 0, 4'hF, 0, 0, 0);
        chk("plan_exc_end", {exception_o, cmd_busy_o, halted_o[2]}, 3'b001);
        step(1, 1, 'h100, 1, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 4'hF, 0, 1, 1);
        step(1, 0, 'h400, 0, 4'hF, 0, 0, 0);
        chk("plan_resume_flag", rdata_o, 32'h0000_0200);
        step(1, 1, 'h110, 1, 4'hF, 0, 0, 0);
        chk("plan_resumeack", resumeack_o, 4'b0010);
        step(1, 1, 'h384, 32'hDEAD_BEEF, 4'b0011, 0, 0, 0);
        step(1, 1, 'h100, 5, 4'hF, 0, 0, 0);
        chk("plan_bad_hart", err_o, 1);
        step(1, 0, 'h100, 0, 4'hF, 0, 0, 0);
        step(1, 1, 'h400, 0, 4'hF, 0, 0, 0);
        step(1, 1, 'h300, 0, 4'hF, 0, 0, 0);
        step(1, 0, 'h200, 0, 4'hF, 0, 0, 0);
        step(1, 1, 'h100, 3, 4'hF, 1, 0, 3);
        chk("plan_write_then_go", cmd_busy_o, 1);
        step(1, 1, 'h100, 3, 4'hF, 0, 0, 0);

        // Random traffic.
        for (int k = 0; k < 500; k++) begin
            sel = $urandom_range(0, 11);
            case (sel)
                0: a = 'h100;
                1: a = 'h108;
                2: a = 'h110;
                3: a = 'h118;
                4: a = 'h300;
                5: a = 'h380;
                6: a = 'h384;
                7: a = 'h360 + 4 * $urandom_range(0, 7);
                8: a = 'h338 + 4 * $urandom_range(0, 9);
                9: a = 'h400 + 4 * $urandom_range(0, 1);
                10: a = $urandom_range(0, 4095);
                default: a = 'h100;
            endcase
            hi = $urandom;
            a = {hi[31:12], a[11:0]};
            r = $urandom_range(0, 7);
            wd = (r == 7) ? $urandom : 32'(r);
            be = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            step($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, a, wd, be,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)));
        end

        // Asynchronous reset while a command is pending.
        step(1, 1, 'h100, 0, 4'hF, 0, 0, 0);
        step(0, 0, 0, 0, 4'hF, 1, 0, 0);
        step(1, 0, 'h300, 0, 4'hF, 0, 0, 0);
        #2 rst_i = 1;
        #1;
        chk("arst_rvalid", rvalid_o, 0);
        chk("arst_rdata", rdata_o, 0);
        chk("arst_busy", cmd_busy_o, 0);
        chk("arst_halted", halted_o, 0);
        chk("arst_pulses", {resumeack_o, exception_o, err_o}, 0);
        model_reset();
        @(posedge clk_i);
        #1 rst_i = 0;
        step(1, 0, 'h300, 0, 4'hF, 0, 0, 0);
        step(1, 0, 'h400, 0, 4'hF, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
